// File: rtl/srv_icb_rr_sched.sv
// srv_icb_rr_sched
// Shares one downstream ICB port between G_US_NUM upstream requesters.
// Commands are granted round-robin, and the grant stays locked while the
// downstream side stalls. At most G_MPX transactions can be outstanding.
// An ID FIFO records the issue order, so each in-order response goes back
// to the requester that issued it.
// The block outputs only one-hot mux selects and handshakes. It does not
// carry any payload.
module srv_icb_rr_sched #(
    parameter int G_US_NUM = 2,
    parameter int G_MPX    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         active,
    input  logic [G_US_NUM-1:0]          req_valid,
    output logic [G_US_NUM-1:0]          req_ready,
    output logic [G_US_NUM-1:0]          cmd_sel,
    output logic                         ds_cmd_valid,
    input  logic                         ds_cmd_ready,
    input  logic                         ds_resp_valid,
    output logic                         ds_resp_ready,
    output logic [G_US_NUM-1:0]          resp_sel,
    output logic [G_US_NUM-1:0]          us_resp_valid,
    input  logic [G_US_NUM-1:0]          us_resp_ready,
    output logic [$clog2(G_MPX+1)-1:0]   pend_cnt
);

    localparam int IW = (G_US_NUM > 1) ? $clog2(G_US_NUM) : 1;
    localparam int PW = (G_MPX > 1) ? $clog2(G_MPX) : 1;
    localparam int CW = $clog2(G_MPX + 1);

    // One-hot decode of a requester index.
    function automatic logic [G_US_NUM-1:0] onehot_f(input logic [IW-1:0] idx);
        logic [G_US_NUM-1:0] vec;
        vec = {G_US_NUM{1'b0}};
        for (int i = 0; i < G_US_NUM; i++) begin
            vec[i] = (idx == IW'(i));
        end
        return vec;
    endfunction

    // FIFO pointer increment that wraps at G_MPX-1. G_MPX need not be a power of 2.
    function automatic logic [PW-1:0] ptr_inc_f(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(G_MPX - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    // Round-robin successor of a requester index.
    function automatic logic [IW-1:0] rr_inc_f(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (idx == IW'(G_US_NUM - 1)) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + IW'(1);
        end
        return nxt;
    endfunction

    logic [IW-1:0]       rr_ptr_r;
    logic                lock_r;
    logic [IW-1:0]       lock_idx_r;
    logic [IW-1:0]       id_mem_r [G_MPX];
    logic [PW-1:0]       rd_ptr_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [CW-1:0]       pend_cnt_r;

    logic [IW-1:0]       search_idx_s;
    logic [IW-1:0]       grant_s;
    logic                grant_vld_s;
    logic                full_s;
    logic [G_US_NUM-1:0] cmd_sel_s;
    logic                ds_cmd_valid_s;
    logic                cmd_fire_s;
    logic [IW-1:0]       head_s;
    logic [G_US_NUM-1:0] resp_sel_s;
    logic                ds_resp_ready_s;
    logic                resp_fire_s;

    assign full_s = (pend_cnt_r == CW'(G_MPX));

    // Find the first valid requester, starting at rr_ptr and wrapping around.
    always_comb begin
        logic [IW-1:0] idx_v;
        logic          found_v;
        found_v      = 1'b0;
        idx_v        = {IW{1'b0}};
        search_idx_s = {IW{1'b0}};
        for (int k = 0; k < G_US_NUM; k++) begin
            idx_v = IW'((int'(rr_ptr_r) + k) % G_US_NUM);
            if (!found_v && req_valid[idx_v]) begin
                found_v      = 1'b1;
                search_idx_s = idx_v;
            end else begin
                found_v = found_v;
            end
        end
    end

    // Choose the grant. A locked grant overrides the search so the
    // downstream valid/payload stay stable. A locked requester that drops
    // its valid produces no command.
    always_comb begin
        if (lock_r) begin
            grant_s = lock_idx_r;
        end else begin
            grant_s = search_idx_s;
        end
        grant_vld_s = req_valid[grant_s];
        if (grant_vld_s && !full_s) begin
            cmd_sel_s = onehot_f(grant_s);
        end else begin
            cmd_sel_s = {G_US_NUM{1'b0}};
        end
    end

    assign ds_cmd_valid_s = |cmd_sel_s;
    assign cmd_fire_s     = ds_cmd_valid_s & ds_cmd_ready;

    // Response routing follows the FIFO head. It is gated off when nothing is
    // outstanding, so a stray response or a same-cycle push cannot leak through.
    always_comb begin
        head_s = id_mem_r[rd_ptr_r];
        if (pend_cnt_r != {CW{1'b0}}) begin
            resp_sel_s = onehot_f(head_s);
        end else begin
            resp_sel_s = {G_US_NUM{1'b0}};
        end
    end

    assign ds_resp_ready_s = |(resp_sel_s & us_resp_ready);
    assign resp_fire_s     = ds_resp_valid & ds_resp_ready_s;

    // Arbitration state: lock while stalled, advance the round-robin pointer on fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= {IW{1'b0}};
            lock_r     <= 1'b0;
            lock_idx_r <= {IW{1'b0}};
        end else if (cmd_fire_s) begin
            lock_r   <= 1'b0;
            rr_ptr_r <= rr_inc_f(grant_s);
        end else if (ds_cmd_valid_s && !ds_cmd_ready) begin
            lock_r     <= 1'b1;
            lock_idx_r <= grant_s;
        end else if (lock_r && !req_valid[lock_idx_r]) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= lock_r;
        end
    end

    // ID FIFO: push the granted index on cmd fire, pop on resp fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < G_MPX; i++) begin
                id_mem_r[i] <= {IW{1'b0}};
            end
        end else begin
            if (cmd_fire_s) begin
                id_mem_r[wr_ptr_r] <= grant_s;
                wr_ptr_r           <= ptr_inc_f(wr_ptr_r);
            end
            if (resp_fire_s) begin
                rd_ptr_r <= ptr_inc_f(rd_ptr_r);
            end
        end
    end

    // Outstanding count. A simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt_r <= {CW{1'b0}};
        end else begin
            case ({cmd_fire_s, resp_fire_s})
                2'b10:   pend_cnt_r <= pend_cnt_r + CW'(1);
                2'b01:   pend_cnt_r <= pend_cnt_r - CW'(1);
                default: pend_cnt_r <= pend_cnt_r;
            endcase
        end
    end

    assign cmd_sel       = cmd_sel_s;
    assign ds_cmd_valid  = ds_cmd_valid_s;
    assign req_ready     = cmd_sel_s & {G_US_NUM{ds_cmd_ready}};
    assign resp_sel      = resp_sel_s;
    assign us_resp_valid = resp_sel_s & {G_US_NUM{ds_resp_valid}};
    assign ds_resp_ready = ds_resp_ready_s;
    assign pend_cnt      = pend_cnt_r;
    assign active        = (pend_cnt_r != {CW{1'b0}}) | (|req_valid);

endmodule

// File: tb/tb_srv_icb_rr_sched.sv
// Directed testbench for srv_icb_rr_sched with G_US_NUM=2 and G_MPX=2.
// Inputs change 1 time unit after a rising edge. Outputs are compared
// 1 time unit later, well before the next rising edge.
module tb_srv_icb_rr_sched;

    logic       clk;
    logic       reset;
    logic       active;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] cmd_sel;
    logic       ds_cmd_valid;
    logic       ds_cmd_ready;
    logic       ds_resp_valid;
    logic       ds_resp_ready;
    logic [1:0] resp_sel;
    logic [1:0] us_resp_valid;
    logic [1:0] us_resp_ready;
    logic [1:0] pend_cnt;

    int n_checks;
    int n_fail;

    srv_icb_rr_sched #(.G_US_NUM(2), .G_MPX(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .cmd_sel       (cmd_sel),
        .ds_cmd_valid  (ds_cmd_valid),
        .ds_cmd_ready  (ds_cmd_ready),
        .ds_resp_valid (ds_resp_valid),
        .ds_resp_ready (ds_resp_ready),
        .resp_sel      (resp_sel),
        .us_resp_valid (us_resp_valid),
        .us_resp_ready (us_resp_ready),
        .pend_cnt      (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] rv, input logic cr, input logic rsv, input logic [1:0] urr);
        req_valid     = rv;
        ds_cmd_ready  = cr;
        ds_resp_valid = rsv;
        us_resp_ready = urr;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        next_cycle();
        next_cycle();
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_pend got=%0d exp=0", pend_cnt); end
        n_checks++; if (cmd_sel !== 2'b00) begin n_fail++; $display("FAIL rst_cmd_sel got=%b exp=00", cmd_sel); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rst_active got=%b exp=0", active); end
        reset = 1'b0;
        next_cycle();
        // A response with nothing outstanding is ignored.
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        n_checks++; if (ds_resp_ready !== 1'b0) begin n_fail++; $display("FAIL empty_resp_ready got=%b exp=0", ds_resp_ready); end
        n_checks++; if (us_resp_valid !== 2'b00) begin n_fail++; $display("FAIL empty_us_resp_valid got=%b exp=00", us_resp_valid); end
        n_checks++; if (resp_sel !== 2'b00) begin n_fail++; $display("FAIL empty_resp_sel got=%b exp=00", resp_sel); end
        next_cycle();
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL empty_pend got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_single();
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
        n_checks++; if (cmd_sel !== 2'b01) begin n_fail++; $display("FAIL single_cmd_sel got=%b exp=01", cmd_sel); end
        n_checks++; if (ds_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_ds_cmd_valid got=%b exp=1", ds_cmd_valid); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 2'b01);
        n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL single_pend1 got=%0d exp=1", pend_cnt); end
        n_checks++; if (us_resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_us_resp_valid got=%b exp=01", us_resp_valid); end
        n_checks++; if (ds_resp_ready !== 1'b1) begin n_fail++; $display("FAIL single_resp_ready got=%b exp=1", ds_resp_ready); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL single_pend0 got=%0d exp=0", pend_cnt); end
    endtask

    // rr_ptr is 1 after test_single, so the grants go 1,0,1,0.
    // Each response returns the previous cycle's grant.
    task automatic test_round_robin();
        logic [1:0] exp_cmd [4];
        logic [1:0] exp_usr [4];
        exp_cmd[0] = 2'b10; exp_cmd[1] = 2'b01; exp_cmd[2] = 2'b10; exp_cmd[3] = 2'b01;
        exp_usr[0] = 2'b00; exp_usr[1] = 2'b10; exp_usr[2] = 2'b01; exp_usr[3] = 2'b10;
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, 1'b1, 2'b11);
            n_checks++; if (cmd_sel !== exp_cmd[c]) begin n_fail++; $display("FAIL rr_cmd_sel[%0d] got=%b exp=%b", c, cmd_sel, exp_cmd[c]); end
            n_checks++; if (us_resp_valid !== exp_usr[c]) begin n_fail++; $display("FAIL rr_us_resp_valid[%0d] got=%b exp=%b", c, us_resp_valid, exp_usr[c]); end
            next_cycle();
        end
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        n_checks++; if (us_resp_valid !== 2'b01) begin n_fail++; $display("FAIL rr_drain got=%b exp=01", us_resp_valid); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL rr_pend got=%0d exp=0", pend_cnt); end
    endtask

    // rr_ptr=1. The stall locks onto requester 0. Without the lock, req=11
    // would switch the grant to 1.
    task automatic test_stall_lock();
        for (int c = 0; c < 3; c++) begin
            drive(2'b01, 1'b0, 1'b0, 2'b00);
            n_checks++; if (cmd_sel !== 2'b01 || req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_cmd_sel[%0d] got=%b/%b exp=01/00", c, cmd_sel, req_ready); end
            next_cycle();
        end
        drive(2'b11, 1'b0, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b01) begin n_fail++; $display("FAIL stall_locked got=%b exp=01", cmd_sel); end
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_fire got=%b exp=01", req_ready); end
        next_cycle();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b10) begin n_fail++; $display("FAIL stall_next_grant got=%b exp=10", cmd_sel); end
        next_cycle();
    endtask

    // Two commands are outstanding (0 then 1), and rr_ptr is 0.
    task automatic test_full();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL full_pend got=%0d exp=2", pend_cnt); end
        n_checks++; if (ds_cmd_valid !== 1'b0 || cmd_sel !== 2'b00) begin n_fail++; $display("FAIL full_blocked got=%b/%b exp=0/00", ds_cmd_valid, cmd_sel); end
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL full_active got=%b exp=1", active); end
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        n_checks++; if (us_resp_valid !== 2'b01 || ds_resp_ready !== 1'b1) begin n_fail++; $display("FAIL full_resp got=%b/%b exp=01/1", us_resp_valid, ds_resp_ready); end
        n_checks++; if (ds_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got=%b exp=0", ds_cmd_valid); end
        next_cycle();
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL full_pend1 got=%0d exp=1", pend_cnt); end
        n_checks++; if (cmd_sel !== 2'b01) begin n_fail++; $display("FAIL full_cmd_next got=%b exp=01", cmd_sel); end
        n_checks++; if (us_resp_valid !== 2'b10) begin n_fail++; $display("FAIL full_resp2 got=%b exp=10", us_resp_valid); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        n_checks++; if (us_resp_valid !== 2'b01) begin n_fail++; $display("FAIL full_resp3 got=%b exp=01", us_resp_valid); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL full_drained got=%0d exp=0", pend_cnt); end
    endtask

    // rr_ptr=1. Commands issue from 1, then 0. Responses must come back in that order.
    task automatic test_ordering();
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b10) begin n_fail++; $display("FAIL ord_cmd1 got=%b exp=10", cmd_sel); end
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b01) begin n_fail++; $display("FAIL ord_cmd0 got=%b exp=01", cmd_sel); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 2'b01);
        n_checks++; if (ds_resp_ready !== 1'b0 || us_resp_valid !== 2'b10) begin n_fail++; $display("FAIL ord_hold got=%b/%b exp=0/10", ds_resp_ready, us_resp_valid); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        n_checks++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL ord_pend got=%0d exp=2", pend_cnt); end
        n_checks++; if (us_resp_valid !== 2'b10 || ds_resp_ready !== 1'b1) begin n_fail++; $display("FAIL ord_first got=%b/%b exp=10/1", us_resp_valid, ds_resp_ready); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        n_checks++; if (us_resp_valid !== 2'b01) begin n_fail++; $display("FAIL ord_second got=%b exp=01", us_resp_valid); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL ord_drained got=%0d exp=0", pend_cnt); end
    endtask

    // rr_ptr=1. The locked requester drops its valid. That cycle has no fire,
    // and the lock is released afterwards.
    task automatic test_lock_drop();
        drive(2'b10, 1'b0, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b10) begin n_fail++; $display("FAIL drop_lock got=%b exp=10", cmd_sel); end
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b00 || req_ready !== 2'b00) begin n_fail++; $display("FAIL drop_nofire got=%b/%b exp=00/00", cmd_sel, req_ready); end
        next_cycle();
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL drop_pend got=%0d exp=0", pend_cnt); end
        n_checks++; if (cmd_sel !== 2'b01) begin n_fail++; $display("FAIL drop_regrant got=%b exp=01", cmd_sel); end
        next_cycle();
    endtask

    // State: pend=1, rr_ptr=1. Lock onto requester 1, then assert reset mid-cycle.
    task automatic test_async_reset();
        drive(2'b10, 1'b0, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b10 || pend_cnt !== 2'd1) begin n_fail++; $display("FAIL ar_setup got=%b/%0d exp=10/1", cmd_sel, pend_cnt); end
        next_cycle();
        #1;
        reset = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL ar_pend got=%0d exp=0", pend_cnt); end
        n_checks++; if (resp_sel !== 2'b00 || cmd_sel !== 2'b00) begin n_fail++; $display("FAIL ar_sel got=%b/%b exp=00/00", resp_sel, cmd_sel); end
        next_cycle();
        reset = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        n_checks++; if (cmd_sel !== 2'b01) begin n_fail++; $display("FAIL ar_first_grant got=%b exp=01", cmd_sel); end
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        test_reset();
        test_single();
        test_round_robin();
        test_stall_lock();
        test_full();
        test_ordering();
        test_lock_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
